// File: rtl/buffer_access_ctrl.sv
// Buffer access controller: UART byte writes into a 16-entry buffer,
// compute-side reads with fixed operand-memory latency.
module buffer_access_ctrl #(
  parameter int READ_LAT   = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic                  w_RX_DV,
  input  logic                  SW,
  input  logic                  rd_req,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2-1:0] count_w,
  output logic [DEPTH_LOG2-1:0] count_r,
  output logic [3:0]            clk_delay,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [3:0] LAT = 4'(READ_LAT);
  localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ZERO = '0;

  logic [DEPTH_LOG2:0]   occ, occ_n;
  logic                  pending, pend_n;
  logic [1:0]            state_n;
  logic [DEPTH_LOG2-1:0] cw_n, cr_n, addr_n;
  logic [3:0]            cd_n;
  logic                  we_n, rv_n, ovf_n;
  logic                  wr_req, wr_go;

  // Next-state: writes win the port, reads hold it for the full latency
  always_comb begin
    state_n = state;
    cw_n    = count_w;
    cr_n    = count_r;
    cd_n    = clk_delay;
    occ_n   = occ;
    pend_n  = pending;
    ovf_n   = overflow;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    rv_n    = 1'b0;
    wr_req  = 1'b0;
    wr_go   = 1'b0;
    unique case (state)
      ST_WAIT: begin
        if (w_RX_DV) begin
          if (pending) ovf_n = 1'b1;
          else         pend_n = 1'b1;
        end
        if (clk_delay <= 4'd1) begin
          rv_n    = 1'b1;
          cr_n    = count_r + 1'b1;
          occ_n   = occ - 1'b1;
          cd_n    = 4'd0;
          state_n = SW ? ST_RUN : ST_LOAD;
        end else begin
          cd_n = clk_delay - 4'd1;
        end
      end
      ST_LOAD, ST_RUN: begin
        wr_req = pending | w_RX_DV;
        pend_n = 1'b0;
        if (pending && w_RX_DV) ovf_n = 1'b1;
        if (wr_req) begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            wr_go  = 1'b1;
            we_n   = 1'b1;
            addr_n = count_w;
            cw_n   = count_w + 1'b1;
            occ_n  = occ + 1'b1;
          end
        end
        if (state == ST_LOAD) begin
          if (SW) state_n = ST_RUN;
        end else if (!SW) begin
          state_n = ST_LOAD;
        end else if (rd_req && !empty && !wr_go) begin
          addr_n  = count_r;
          state_n = ST_WAIT;
          cd_n    = LAT;
        end
      end
      default: state_n = ST_LOAD;
    endcase
  end

  // State and output registers; reset aborts any read in flight
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      count_w   <= '0;
      count_r   <= '0;
      clk_delay <= '0;
      occ       <= '0;
      pending   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state     <= state_n;
      count_w   <= cw_n;
      count_r   <= cr_n;
      clk_delay <= cd_n;
      occ       <= occ_n;
      pending   <= pend_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      rd_valid  <= rv_n;
      overflow  <= ovf_n;
      full      <= (occ_n == CAP);
      empty     <= (occ_n == ZERO);
    end
  end

endmodule

// File: tb/tb_buffer_access_ctrl.sv
// Bench for buffer_access_ctrl: write/read address scoreboard
// plus directed checks on flags, pointers and read latency.
module tb_buffer_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_RX_DV = 1'b0;
  logic       SW = 1'b0;
  logic       rd_req = 1'b0;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic       rd_valid;
  logic [3:0] count_w;
  logic [3:0] count_r;
  logic [3:0] clk_delay;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] wq[$];
  logic [3:0] rq[$];

  buffer_access_ctrl #(.READ_LAT(2), .DEPTH_LOG2(4)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .w_RX_DV  (w_RX_DV),
    .SW       (SW),
    .rd_req   (rd_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .rd_valid (rd_valid),
    .count_w  (count_w),
    .count_r  (count_r),
    .clk_delay(clk_delay),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe and every read-valid pops an expected address
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) chk("wr_unexp", mem_we, 0);
      else                chk("wr_addr", mem_addr, wq.pop_front());
    end
    if (rd_valid === 1'b1) begin
      if (rq.size() == 0) chk("rd_unexp", rd_valid, 0);
      else                chk("rd_addr", mem_addr, rq.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      w_RX_DV = 1'b1;
      step();
    end
    w_RX_DV = 1'b0;
  endtask

  task automatic do_reset();
    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
    wq.delete();
    rq.delete();
    w_RX_DV = 1'b0;
    SW      = 1'b0;
    rd_req  = 1'b0;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", state, 0);
    chk("rst_cw", count_w, 0);
    chk("rst_cr", count_r, 0);
    chk("rst_cd", clk_delay, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
  endtask

  initial begin
    // Asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1 chk_reset_vals();
    step();
    rst = 1'b0;

    // Three bytes in LOAD
    wq.push_back(4'd0);
    wq.push_back(4'd1);
    wq.push_back(4'd2);
    pulse(3);
    chk("l3_cw", count_w, 3);
    chk("l3_empty", empty, 0);
    chk("l3_state", state, 0);
    step();
    chk("l3_we_idle", mem_we, 0);

    // Fill to 16, then two dropped bytes
    do_reset();
    for (int i = 0; i < 16; i++) wq.push_back(4'(i));
    pulse(16);
    chk("f16_full", full, 1);
    chk("f16_ovf", overflow, 0);
    chk("f16_cw", count_w, 0);
    pulse(2);
    chk("f18_ovf", overflow, 1);
    chk("f18_full", full, 1);
    chk("f18_cw", count_w, 0);
    chk("f18_we", mem_we, 0);

    // Two loaded bytes read back with latency 2
    do_reset();
    wq.push_back(4'd0);
    wq.push_back(4'd1);
    pulse(2);
    rq.push_back(4'd0);
    rq.push_back(4'd1);
    SW = 1'b1;
    rd_req = 1'b1;
    step();
    chk("r_run", state, 1);
    step();
    chk("r_issue", state, 2);
    chk("r_addr0", mem_addr, 0);
    chk("r_cd2", clk_delay, 2);
    chk("r_we0", mem_we, 0);
    step();
    chk("r_cd1", clk_delay, 1);
    chk("r_rv_early", rd_valid, 0);
    step();
    chk("r_rv1", rd_valid, 1);
    chk("r_cr1", count_r, 1);
    chk("r_back", state, 1);
    chk("r_cd0", clk_delay, 0);
    step();
    chk("r_issue2", state, 2);
    chk("r_addr1", mem_addr, 1);
    step(2);
    chk("r_rv2", rd_valid, 1);
    chk("r_cr2", count_r, 2);
    chk("r_empty", empty, 1);
    rd_req = 1'b0;
    step();
    chk("r_idle", state, 1);

    // Write and eligible read on the same edge: write first
    do_reset();
    wq.push_back(4'd0);
    pulse(1);
    SW = 1'b1;
    step();
    rd_req = 1'b1;
    w_RX_DV = 1'b1;
    wq.push_back(4'd1);
    step();
    w_RX_DV = 1'b0;
    chk("p_we", mem_we, 1);
    chk("p_defer", state, 1);
    rq.push_back(4'd0);
    step();
    chk("p_issue", state, 2);
    chk("p_addr", mem_addr, 0);
    SW = 1'b0;
    step();
    chk("p_hold", state, 2);
    step();
    chk("p_rv", rd_valid, 1);
    chk("p_load", state, 0);
    rd_req = 1'b0;
    step();
    chk("p_stay", state, 0);

    // Two bytes during one WAIT: one pending, one dropped
    do_reset();
    wq.push_back(4'd0);
    pulse(1);
    SW = 1'b1;
    step();
    rd_req = 1'b1;
    rq.push_back(4'd0);
    step();
    chk("w_wait", state, 2);
    w_RX_DV = 1'b1;
    step();
    chk("w_ovf0", overflow, 0);
    chk("w_we0", mem_we, 0);
    step();
    w_RX_DV = 1'b0;
    rd_req = 1'b0;
    chk("w_ovf1", overflow, 1);
    chk("w_rv", rd_valid, 1);
    chk("w_we1", mem_we, 0);
    wq.push_back(4'd1);
    step();
    chk("w_pend_we", mem_we, 1);
    chk("w_cw", count_w, 2);
    chk("w_run", state, 1);
    step();
    chk("w_single", mem_we, 0);
    chk("w_sticky", overflow, 1);

    // Reset in the middle of a read
    do_reset();
    wq.push_back(4'd0);
    pulse(1);
    SW = 1'b1;
    step();
    rd_req = 1'b1;
    step();
    chk("m_wait", state, 2);
    step();
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    step(2);
    chk("m_norv", rd_valid, 0);
    rst = 1'b0;
    rd_req = 1'b0;
    SW = 1'b0;
    wq.push_back(4'd0);
    pulse(1);
    chk("m_cw", count_w, 1);
    chk("m_load", state, 0);
    step();

    chk("wq_end", wq.size(), 0);
    chk("rq_end", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_access_ctrl.md
BUFFER_ACCESS_CTRL -- requirements
Module: buffer_access_ctrl

Interface
REQ-001 Parameter READ_LAT, default 2, operand-memory read latency in clock cycles; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, fixed 4, buffer address width; buffer holds 16 entries.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 w_RX_DV  in  1  UART byte-valid, single-cycle pulse per received byte.
REQ-006 SW  in  1  mode select: 0 = load, 1 = run.
REQ-007 rd_req  in  1  compute-side read request, level, held until rd_valid.
REQ-008 mem_we  out  1  buffer write strobe.
REQ-009 mem_addr  out  4  buffer address, write or read.
REQ-010 rd_valid  out  1  read data valid on buffer output, one-cycle pulse.
REQ-011 count_w  out  4  write pointer.
REQ-012 count_r  out  4  read pointer.
REQ-013 clk_delay  out  4  remaining read-wait cycles.
REQ-014 full, empty  out  1 each  occupancy flags.
REQ-015 overflow  out  1  sticky dropped-byte flag.
REQ-016 state  out  2  FSM state: 0 LOAD, 1 RUN, 2 WAIT.

Function
REQ-017 All outputs registered; internal 5-bit occupancy occ (0..16); full = (occ==16), empty = (occ==0).
REQ-018 Write grant: w_RX_DV sampled at edge k with port free and !full -> mem_we=1, mem_addr=count_w during cycle k+1; count_w+1 (mod 16) and occ+1 at edge k.
REQ-019 Port free means state != WAIT; writes are granted in both LOAD and RUN.
REQ-020 w_RX_DV while state==WAIT sets one-deep pending flag; pending write is granted at the first edge the port is free, with identical effects to REQ-018.
REQ-021 w_RX_DV while pending flag already set -> byte dropped, overflow=1.
REQ-022 Write (direct or pending) when full -> dropped, no pointer/occ change, overflow=1.
REQ-023 overflow clears only on reset.
REQ-024 LOAD: no read issued; SW=1 -> RUN next edge.
REQ-025 RUN: SW=0 -> LOAD next edge; else read issue when rd_req=1, !empty, and no write (direct or pending) granted at that edge.
REQ-026 Write has priority over read issue at the same edge; the read issues at the next eligible edge.
REQ-027 Read issue at edge T: mem_addr=count_r, mem_we=0, state=WAIT, clk_delay=READ_LAT.
REQ-028 WAIT: mem_addr held at count_r; clk_delay decrements by 1 per edge.
REQ-029 rd_valid=1 for exactly the cycle following edge T+READ_LAT; at that edge count_r+1 (mod 16), occ-1, clk_delay=0, state returns to RUN (or LOAD if SW=0).
REQ-030 SW change during WAIT has no effect until the read completes.
REQ-031 Direct write and read completion at the same edge is impossible (write deferred); pending write granted at completion edge+1.
REQ-032 Pointer wrap 15->0 silent; occ never exceeds 16 nor underflows 0.
REQ-033 mem_we=0 in every cycle not following a granted write.

Reset
REQ-034 rst=1 forces immediately: state=LOAD, count_w=0, count_r=0, clk_delay=0, occ=0, pending=0, mem_we=0, mem_addr=0, rd_valid=0, overflow=0, full=0, empty=1.
REQ-035 Reset mid-WAIT aborts the read; no rd_valid is produced.
REQ-036 First edge after rst deasserts behaves as a normal LOAD-state edge.

Verification
REQ-037 SW=0, 3 w_RX_DV pulses -> 3 mem_we pulses at addr 0,1,2; count_w=3, empty=0.
REQ-038 18 pulses in LOAD -> 16 writes, full=1, overflow=1, count_w=0 (wrapped).
REQ-039 READ_LAT=2, 2 bytes loaded, SW=1, rd_req held -> issue addr 0, rd_valid 2 cycles later, count_r=1; second read addr 1; empty=1 after.
REQ-040 w_RX_DV in same cycle as eligible read issue -> write granted first, read issues one edge later.
REQ-041 Two w_RX_DV pulses during one WAIT -> first written after completion, second dropped, overflow=1.
REQ-042 rst pulse mid-WAIT -> all outputs per REQ-034, no rd_valid.
